conv_relu_pool: RTL and testbench

//  Post-processing stage directly downstream of the 5x5 convolution engine.

---
 rtl/conv_relu_pool.sv | 170 +++++++++++++++++
 tb/tb_conv_relu_pool.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// Post-processing stage after the 5x5 conv engine: raster tracking, full-window filter,
// ReLU + rounded/saturated requant to 7 bits, and 2x2/stride-2 max-pooling.
module conv_relu_pool #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned LAT   = 6,
    parameter int unsigned SHIFT = 4,
    parameter int unsigned BW    = 16
) (
    input  logic                 iCLK,
    input  logic                 iRSTn,
    input  logic                 iStart,
    input  logic                 iXValid,
    input  logic signed [BW-1:0] iPsum,
    output logic                 oValid,
    output logic [7:0]           oData,
    output logic [4:0]           oRow,
    output logic [4:0]           oCol,
    output logic                 oBusy,
    output logic                 oDone
);
    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned POW = (IMG_W - 4) / 2;
    localparam int unsigned POH = (IMG_H - 4) / 2;
    localparam int unsigned PW  = BW + 1;
    localparam int unsigned LBW = (POW > 1) ? $clog2(POW) : 1;
    localparam logic [PW-1:0] HALF = PW'(2 ** (SHIFT - 1));

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t         state_q, state_d;
    logic [LAT-1:0] dv_q;
    logic [CW-1:0]  c_q, c_d;
    logic [RW-1:0]  r_q, r_d;
    logic           done_d, busy_d;
    logic           dv, win;

    logic [PW-1:0]  p, rnd, sh;
    logic [6:0]     q;

    logic           s1_v_q;
    logic [6:0]     s1_q_q;
    logic [RW-1:0]  s1_i_q;
    logic [CW-1:0]  s1_j_q;

    logic [6:0]     hreg_q;
    logic [6:0]     lb_q [POW];
    logic [6:0]     h, pm;
    logic [LBW-1:0] lbi;
    logic           in_pool;

    logic           valid_q, busy_q, done_q;
    logic [7:0]     data_q;
    logic [4:0]     row_q, col_q;

    assign dv  = dv_q[LAT-1];
    assign win = (state_q == ST_RUN) && !iStart && dv &&
                 (r_q >= RW'(4)) && (c_q >= CW'(4));

    // Frame FSM: raster counters advance on dv only; iStart restarts from any state.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        done_d  = 1'b0;
        if (iStart) begin
            state_d = ST_RUN;
            c_d     = '0;
            r_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (dv) begin
                        if (c_q == CW'(IMG_W - 1)) begin
                            c_d = '0;
                            if (r_q == RW'(IMG_H - 1)) state_d = ST_DONE;
                            else                        r_d     = r_q + RW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // ReLU then round-half-up right shift, saturated to 127.
    always_comb begin
        p   = iPsum[BW-1] ? '0 : {1'b0, iPsum};
        rnd = p + HALF;
        sh  = rnd >> SHIFT;
        q   = (sh > PW'(127)) ? 7'd127 : sh[6:0];
    end

    always_comb begin
        lbi     = LBW'(s1_j_q >> 1);
        in_pool = ((s1_j_q >> 1) < CW'(POW)) && ((s1_i_q >> 1) < RW'(POH));
        h       = (hreg_q > s1_q_q) ? hreg_q : s1_q_q;
        pm      = h;
        if (in_pool && (lb_q[lbi] > h)) pm = lb_q[lbi];
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= ST_IDLE;
            dv_q    <= '0;
            c_q     <= '0;
            r_q     <= '0;
            s1_v_q  <= 1'b0;
            s1_q_q  <= '0;
            s1_i_q  <= '0;
            s1_j_q  <= '0;
            hreg_q  <= '0;
            for (int k = 0; k < int'(POW); k++) lb_q[k] <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dv_q    <= iStart ? '0 : ((dv_q << 1) | LAT'(iXValid));
            s1_v_q  <= win;
            if (win) begin
                s1_q_q <= q;
                s1_i_q <= r_q - RW'(4);
                s1_j_q <= c_q - CW'(4);
            end
            valid_q <= 1'b0;
            // Results still in flight when a restart arrives are dropped.
            if (iStart) begin
                hreg_q <= '0;
            end else if (s1_v_q) begin
                if (!s1_j_q[0]) begin
                    hreg_q <= s1_q_q;
                end else if (in_pool) begin
                    if (!s1_i_q[0]) begin
                        lb_q[lbi] <= h;
                    end else begin
                        valid_q <= 1'b1;
                        data_q  <= {1'b0, pm};
                        row_q   <= 5'(s1_i_q >> 1);
                        col_q   <= 5'(s1_j_q >> 1);
                    end
                end
            end
        end
    end

    assign oValid = valid_q;
    assign oData  = data_q;
    assign oRow   = row_q;
    assign oCol   = col_q;
    assign oBusy  = busy_q;
    assign oDone  = done_q;

endmodule

// File: tb/tb_conv_relu_pool.sv
// Bench for conv_relu_pool: models the conv engine's LAT-cycle psum delay and scoreboards
// every pooled output (value, position, arrival cycle) plus frame-done behaviour.
module tb_conv_relu_pool;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int LAT   = 6;
    localparam int SHIFT = 4;
    localparam int BW    = 16;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int POW   = (IMG_W - 4) / 2;
    localparam int POH   = (IMG_H - 4) / 2;
    localparam int NV    = 8;

    localparam int M_CONST = 0;
    localparam int M_POOL  = 1;
    localparam int M_RAND  = 2;

    typedef struct {
        int mode;
        int val;
        int border;
        int gap;
        int expv;
    } vec_t;

    typedef struct {
        int data;
        int row;
        int col;
        int cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 iRSTn;
    logic                 iStart;
    logic                 iXValid;
    logic signed [BW-1:0] iPsum;
    logic                 oValid;
    logic [7:0]           oData;
    logic [4:0]           oRow;
    logic [4:0]           oCol;
    logic                 oBusy;
    logic                 oDone;

    conv_relu_pool #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .LAT(LAT), .SHIFT(SHIFT), .BW(BW)
    ) dut (
        .iCLK(clk), .iRSTn(iRSTn), .iStart(iStart), .iXValid(iXValid), .iPsum(iPsum),
        .oValid(oValid), .oData(oData), .oRow(oRow), .oCol(oCol),
        .oBusy(oBusy), .oDone(oDone)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   out_cnt, done_cnt, done_cyc, last_cyc, last_data;
    int   pmap [IMG_H][IMG_W];
    int   pipe [$];
    exp_t exp_q [$];
    vec_t cur;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int rq(input int ps);
        int t;
        if (ps < 0) return 0;
        t = (ps + (1 << (SHIFT - 1))) >>> SHIFT;
        return (t > 127) ? 127 : t;
    endfunction

    // One clock: advance, then check whatever the DUT presents in this cycle.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (oValid) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", int'(oData), e.data);
                chk("row", int'(oRow), e.row);
                chk("col", int'(oCol), e.col);
                chk("out_cycle", cyc, e.cyc);
                last_data = int'(oData);
            end
        end
        if (oDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Conv engine model: psum of the pixel fed LAT cycles ago, junk otherwise.
    task automatic feed(input int pix);
        int old;
        pipe.push_back(pix);
        old = -1;
        if (pipe.size() > LAT) old = pipe.pop_front();
        if (old >= 0) iPsum = 16'(pmap[old / IMG_W][old % IMG_W]);
        else          iPsum = 16'($urandom);
    endtask

    task automatic build_map(input vec_t v);
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (v.mode == M_RAND) begin
                    pmap[r][c] = ($urandom_range(0, 9) == 0) ? 32767 : int'($urandom_range(0, 4000)) - 1000;
                end else if (r < 4 || c < 4) begin
                    pmap[r][c] = v.border;
                end else if (v.mode == M_POOL) begin
                    pmap[r][c] = (((r - 4) % 2) == 1 && ((c - 4) % 2) == 0) ? 800 : 16;
                end else begin
                    pmap[r][c] = v.val;
                end
            end
        end
    endtask

    task automatic push_exp(input int k);
        int r, c, i, j, a, b, m;
        exp_t e;
        r = k / IMG_W;
        c = k % IMG_W;
        i = r - 4;
        j = c - 4;
        if (i < 0 || j < 0 || (i % 2) == 0 || (j % 2) == 0) return;
        a = i / 2;
        b = j / 2;
        if (a >= POH || b >= POW) return;
        if (cur.expv >= 0) begin
            m = cur.expv;
        end else begin
            m = 0;
            for (int di = 0; di < 2; di++)
                for (int dj = 0; dj < 2; dj++)
                    if (rq(pmap[4 + 2*a + di][4 + 2*b + dj]) > m) m = rq(pmap[4 + 2*a + di][4 + 2*b + dj]);
        end
        e.data = m;
        e.row  = a;
        e.col  = b;
        e.cyc  = cyc + LAT + 2;
        exp_q.push_back(e);
    endtask

    task automatic restart_cycle();
        iStart  = 1'b1;
        iXValid = 1'b0;
        pipe.delete();
        exp_q.delete();
        feed(-1);
    endtask

    // Drives one frame; optional abort (restart) at pixel abort_at, or stop early at stop_at.
    task automatic run_frame(input vec_t v, input int abort_at, input int stop_at);
        int  k, slot;
        bit  ab;
        cur = v;
        build_map(v);
        out_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
        tick();
        restart_cycle();
        k    = 0;
        slot = 0;
        ab   = 1'b0;
        while (k < NPIX) begin
            tick();
            iStart = 1'b0;
            if (slot == 10) chk("busy_run", int'(oBusy), 1);
            if (k == stop_at) return;
            if (k == abort_at && !ab) begin
                ab = 1'b1;
                restart_cycle();
                out_cnt = 0;
                k = 0;
                continue;
            end
            if (v.gap != 0 && (slot % v.gap) == v.gap - 1) begin
                iXValid = 1'b0;
                feed(-1);
            end else begin
                iXValid = 1'b1;
                feed(k);
                push_exp(k);
                last_cyc = cyc;
                k++;
            end
            slot++;
        end
        tick();
        iXValid = 1'b0;
        feed(-1);
        repeat (LAT + 6) begin
            tick();
            feed(-1);
        end
        chk("n_out", out_cnt, POW * POH);
        chk("leftover", exp_q.size(), 0);
        chk("n_done", done_cnt, 1);
        chk("done_cycle", done_cyc, last_cyc + LAT + 2);
        chk("busy_end", int'(oBusy), 0);
        chk("hold_data", int'(oData), last_data);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(oValid), 0);
        chk({tag, "_data"}, int'(oData), 0);
        chk({tag, "_row"}, int'(oRow), 0);
        chk({tag, "_col"}, int'(oCol), 0);
        chk({tag, "_busy"}, int'(oBusy), 0);
        chk({tag, "_done"}, int'(oDone), 0);
    endtask

    initial begin
        //         mode     val     border gap expv
        tbl[0] = '{M_CONST,  100,    100,   0,   6};
        tbl[1] = '{M_CONST, -500,   -500,   0,   0};
        tbl[2] = '{M_CONST, 32767,  32767,  0, 127};
        tbl[3] = '{M_CONST, -32768, -32768, 0,   0};
        tbl[4] = '{M_POOL,     0,     16,   0,  50};
        tbl[5] = '{M_CONST,  100,  32767,   3,   6};
        tbl[6] = '{M_RAND,     0,      0,   0,  -1};
        tbl[7] = '{M_POOL,     0,  32767,   2,  50};

        iRSTn     = 1'b0;
        iStart    = 1'b0;
        iXValid   = 1'b0;
        iPsum     = '0;
        out_cnt   = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        last_cyc  = 0;
        last_data = 0;
        repeat (3) tick();
        chk_zero("rst0");
        iRSTn = 1'b1;

        for (int t = 0; t < NV; t++) run_frame(tbl[t], -1, -1);

        // Restart mid-frame: first frame yields no oDone, second frame is complete.
        run_frame(tbl[6], 300, -1);

        // Reset held 3 cycles mid-frame, then a clean frame.
        run_frame(tbl[4], -1, 400);
        iRSTn   = 1'b0;
        iXValid = 1'b0;
        exp_q.delete();
        repeat (3) begin
            pipe.delete();
            feed(-1);
            tick();
        end
        chk_zero("rst_mid");
        iRSTn = 1'b1;
        run_frame(tbl[0], -1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
